// File: rtl/l2norm_sqrt_arbiter.sv
// Round-robin arbiter that shares one iterative sqrt unit among NUM_REQ L2-norm lanes.
// Only one operation is in flight; the response is tagged with its lane and carries a timeout flag.
module l2norm_sqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        io_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] io_req_data,
    output logic [NUM_REQ-1:0]        io_req_ready,
    output logic                      io_rsp_valid,
    output logic [DATA_W-1:0]         io_rsp_data,
    output logic [ID_W-1:0]           io_rsp_id,
    output logic                      io_rsp_error,
    input  logic                      io_rsp_ready,
    output logic [DATA_W-1:0]         sqrt_data_in,
    output logic                      sqrt_data_valid,
    input  logic [DATA_W-1:0]         sqrt_data_out,
    input  logic                      sqrt_data_ready
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t            r_state, w_next;
    logic [ID_W-1:0]   r_ptr, r_id;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_op, r_res;
    logic              r_err;

    logic [ID_W-1:0]   w_gnt, w_hi, w_lo;
    logic              w_found, w_hi_f, w_tmo;

    // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        w_hi_f = 1'b0;
        w_found = 1'b0;
        w_hi = '0;
        w_lo = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (io_req_valid[j]) begin
                w_found = 1'b1;
                w_lo = ID_W'(j);
                if (ID_W'(j) >= r_ptr) begin
                    w_hi_f = 1'b1;
                    w_hi = ID_W'(j);
                end
            end
        end
        w_gnt = w_hi_f ? w_hi : w_lo;
    end

    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        io_req_ready = '0;
        sqrt_data_valid = 1'b0;
        sqrt_data_in = '0;
        io_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                // Grant is suppressed while reset is held even though state is already IDLE.
                if (w_found && !reset) io_req_ready[w_gnt] = 1'b1;
                if (w_found) w_next = ISSUE;
            end
            ISSUE: begin
                sqrt_data_valid = 1'b1;
                sqrt_data_in = r_op;
                w_next = sqrt_data_ready ? HOLD : WAIT;
            end
            WAIT: begin
                sqrt_data_in = r_op;
                if (sqrt_data_ready || w_tmo) w_next = HOLD;
            end
            HOLD: begin
                io_rsp_valid = 1'b1;
                if (io_rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign io_rsp_data  = r_res;
    assign io_rsp_id    = r_id;
    assign io_rsp_error = r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_cnt <= '0;
            r_op  <= '0;
            r_res <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_op  <= io_req_data[w_gnt*DATA_W +: DATA_W];
                    r_id  <= w_gnt;
                    r_cnt <= '0;
                end
                ISSUE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (sqrt_data_ready) begin
                        r_res <= sqrt_data_out;
                        r_err <= 1'b0;
                    end
                end
                WAIT: begin
                    // A result arriving on the final counted cycle still beats the timeout.
                    if (sqrt_data_ready) begin
                        r_res <= sqrt_data_out;
                        r_err <= 1'b0;
                    end else if (w_tmo) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HOLD: if (io_rsp_ready)
                    r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + ID_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/l2norm_sqrt_arbiter.md
# l2norm_sqrt_arbiter

Shares one iterative `sqrt` unit among `NUM_REQ` L2-norm lanes. Each lane presents its final sum of squares. The arbiter grants lanes round-robin and issues one operand at a time to the sqrt unit. It waits for the result, with a timeout guard, and returns the result tagged with the lane ID on a single valid/ready response channel. It sits between the per-lane accumulators and the single shared `sqrt` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting lanes (2..16).
- `DATA_W`, 32: operand and result width.
- `ID_W`, `$clog2(NUM_REQ)` (minimum 1): response ID width.
- `TIMEOUT`, 64: maximum cycles to wait for the sqrt result, counted from the issue cycle (at least 2).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `io_req_valid` in `NUM_REQ`: lane i has a sum pending.
- `io_req_data` in `NUM_REQ*DATA_W`: lane i operand in bits `[i*DATA_W +: DATA_W]`.
- `io_req_ready` out `NUM_REQ`: one-hot grant/accept strobe.
- `io_rsp_valid` out 1: response available.
- `io_rsp_data` out `DATA_W`: sqrt result, or 0 on error.
- `io_rsp_id` out `ID_W`: lane index of the response.
- `io_rsp_error` out 1: sqrt unit timed out.
- `io_rsp_ready` in 1: consumer accepts the response.
- `sqrt_data_in` out `DATA_W`: operand to the sqrt unit.
- `sqrt_data_valid` out 1: one-cycle start pulse.
- `sqrt_data_out` in `DATA_W`: sqrt result.
- `sqrt_data_ready` in 1: one-cycle result-valid pulse.

## Operation
FSM states: IDLE, ISSUE, WAIT, HOLD. A round-robin pointer `ptr` is held in a register.

- **IDLE:**
  - Search `io_req_valid` starting at index `ptr`, wrapping modulo `NUM_REQ`. The first set bit is the winner `g`.
  - `io_req_ready[g]`=1 combinationally in the same cycle; all other ready bits are 0. With no valid request, all ready bits are 0.
  - On the handshake, latch `io_req_data[g]` into the operand register and `g` into the ID register, then go to ISSUE.
- **ISSUE:**
  - `sqrt_data_valid`=1 for exactly this cycle.
  - Timeout counter is 0 this cycle.
  - `sqrt_data_ready` is sampled here, so a zero-latency sqrt is supported. If it is seen, capture the result and go to HOLD; otherwise go to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - On `sqrt_data_ready`: latch `sqrt_data_out`, set error=0, go to HOLD.
  - Otherwise, when the counter equals `TIMEOUT-1`: set result=0, error=1, go to HOLD.
- **HOLD:**
  - `io_rsp_valid`=1. Data, ID and error stay stable.
  - On `io_rsp_ready`: set `ptr` = (g+1) mod `NUM_REQ` and go to IDLE.
- `sqrt_data_in` holds the latched operand from ISSUE through the end of WAIT. It is don't-care elsewhere and driven 0.
- `sqrt_data_ready` is ignored in IDLE and HOLD (stray or late pulses).
- Only one operation is in flight at a time. `io_req_ready` is 0 in every state except IDLE.
- Data passes through unmodified: no arithmetic on operands. The counter is `$clog2(TIMEOUT)` bits wide and never wraps.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; `ptr`, counter, operand, ID and result registers go to 0.
  - `io_req_ready`, `io_rsp_valid`, `io_rsp_data`, `io_rsp_id`, `io_rsp_error`, `sqrt_data_valid` and `sqrt_data_in` are all 0.
  - `io_req_ready` is forced to 0 while `reset` is high.
- Request accepted at cycle k. ISSUE pulse at k+1. If `sqrt_data_ready` arrives at cycle t (t ≥ k+1), `io_rsp_valid` rises at t+1.
- Timeout with ISSUE at cycle c: the last sampled cycle is c+TIMEOUT-1, and `io_rsp_valid` with error=1 rises at c+TIMEOUT.
- Response handshake at cycle h: IDLE at h+1, and the earliest next grant is at h+1.
- Minimum period per operation: sqrt latency + 3 cycles.
- Reset mid-operation (ISSUE, WAIT or HOLD): the operation is aborted. No response is ever emitted for it, and a late `sqrt_data_ready` after reset release is ignored.
- `io_req_valid` dropping in IDLE before a handshake: no grant is made and no state change occurs.

## Test plan
- **Single request:** lane 0 operand 81; sqrt model returns 9 after 16 cycles. Expect `io_req_ready[0]` high for 1 cycle, one `sqrt_data_valid` pulse, then the response with data=9, id=0, error=0 one cycle after `sqrt_data_ready`.
- **Round-robin:** all 4 lanes valid continuously, `io_rsp_ready`=1. Grant/response ID order is 0,1,2,3,0,1.
- **Skip empty lanes:** after a grant to lane 2, only lanes 0 and 3 are valid. Next grants are 3, then 0.
- **Backpressure:** `io_rsp_ready`=0 for 10 cycles in HOLD. Response fields stay stable, `io_req_ready` stays 0, no `sqrt_data_valid` pulse occurs, and a stray `sqrt_data_ready` is ignored.
- **Timeout:** `TIMEOUT`=64, sqrt never responds. Response with error=1, data=0 appears exactly 64 cycles after the ISSUE cycle. The next request then proceeds normally with result 5 for operand 25.
- **Reset in WAIT:** assert `reset` mid-WAIT. All outputs go to 0 immediately. After release, no response is emitted, a late `sqrt_data_ready` is ignored, and the next grant starts from lane 0.
